pc_target_table: RTL

- Programmable, parametrised successor to the hard-coded branch-target lookup used by the fetch stage.
- Holds 2**A entries. Each entry is a D-bit value plus a mode bit (absolute target, or PC-relative signed offset) and a valid bit.
- Loaded at run time through a write port. Read with one-cycle registered latency. Supports a multi-cycle flush sequence.
- Sits between the decoder (supplies the lookup index) and the PC register (consumes target and hit).

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_target_table_if.sv | 31 +++
 rtl/pc_target_calc.sv | 20 ++
 rtl/pc_target_table.sv | 113 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and configuration for the PC target table and its helpers.
//   D / A        : PC width and index width.
//   ENTRIES      : table depth.
//   MISS_TARGET  : target driven when a lookup misses (hold-PC convention).
package pc_pkg;
    localparam int D       = 12;
    localparam int A       = 5;
    localparam int ENTRIES = 1 << A;

    typedef logic [D-1:0] pc_t;
    typedef logic [A-1:0] idx_t;

    localparam pc_t MISS_TARGET = '0;

    typedef struct packed {
        logic valid;
        logic rel;   // 1 = data is a signed offset from pc_in
        pc_t  data;
    } entry_t;

    typedef enum logic {IDLE, SWEEP} flush_state_e;
endpackage

// File: rtl/pc_target_table_if.sv
// Request/response bundle between decoder/PC logic (master) and the table (slave).
//   rd_en/rd_addr/pc_in        : lookup request
//   wr_en/wr_addr/wr_data/wr_rel : entry write
//   flush                      : start an invalidate sweep
//   target/hit/rd_valid        : registered lookup result
//   busy                       : sweep in progress
interface pc_target_table_if;
    import pc_pkg::*;

    logic rd_en;
    idx_t rd_addr;
    pc_t  pc_in;
    logic wr_en;
    idx_t wr_addr;
    pc_t  wr_data;
    logic wr_rel;
    logic flush;
    pc_t  target;
    logic hit;
    logic rd_valid;
    logic busy;

    modport master (
        output rd_en, rd_addr, pc_in, wr_en, wr_addr, wr_data, wr_rel, flush,
        input  target, hit, rd_valid, busy
    );
    modport slave (
        input  rd_en, rd_addr, pc_in, wr_en, wr_addr, wr_data, wr_rel, flush,
        output target, hit, rd_valid, busy
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational target resolution for one table entry.
//   ent    : entry (valid, rel, data)
//   pc_in  : current PC, used for relative entries
//   target : data, pc_in+data (mod 2**D), or MISS_TARGET on miss
//   hit    : entry valid
module pc_target_calc
    import pc_pkg::*;
(
    input  entry_t ent,
    input  pc_t    pc_in,
    output pc_t    target,
    output logic   hit
);
    always_comb begin
        hit    = ent.valid;
        target = MISS_TARGET;
        if (ent.valid)
            target = ent.rel ? pc_t'(pc_in + ent.data) : ent.data;
    end
endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table: ENTRIES entries of {valid, rel, data},
// one-cycle registered lookup with write-first bypass, and a flush sweep that
// clears one valid bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pc_target_table_if
module pc_target_table
    import pc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pc_target_table_if.slave   bus
);
    flush_state_e       state_q, state_d;
    idx_t               cnt_q, cnt_d;
    logic [ENTRIES-1:0] vld_q;
    logic [ENTRIES-1:0] rel_q;
    pc_t                data_q [ENTRIES];

    logic   sweeping, wr_ok;
    entry_t rd_ent;
    pc_t    calc_tgt;
    logic   calc_hit;
    pc_t    target_q;
    logic   hit_q, rd_valid_q;

    assign sweeping = (state_q == SWEEP);
    // Writes arriving during a sweep are dropped, not queued.
    assign wr_ok    = bus.wr_en && !sweeping;

    // Flush FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.flush) begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == idx_t'(ENTRIES - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Valid bits: the sweep owns them while active. A write in the flush
    // cycle still lands (state is IDLE) and is cleared later by the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else if (sweeping)
            vld_q[cnt_q] <= 1'b0;
        else if (wr_ok)
            vld_q[bus.wr_addr] <= 1'b1;
    end

    // Payload storage needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_q[bus.wr_addr] <= bus.wr_data;
            rel_q[bus.wr_addr]  <= bus.wr_rel;
        end
    end

    // Read mux with write-first bypass; a sweep forces every lookup to miss.
    always_comb begin
        rd_ent = '{valid: vld_q[bus.rd_addr], rel: rel_q[bus.rd_addr],
                   data: data_q[bus.rd_addr]};
        if (wr_ok && bus.wr_addr == bus.rd_addr)
            rd_ent = '{valid: 1'b1, rel: bus.wr_rel, data: bus.wr_data};
        if (sweeping)
            rd_ent.valid = 1'b0;
    end

    pc_target_calc u_calc (
        .ent    (rd_ent),
        .pc_in  (bus.pc_in),
        .target (calc_tgt),
        .hit    (calc_hit)
    );

    // Result registers hold their last value between lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            target_q   <= MISS_TARGET;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                hit_q    <= calc_hit;
                target_q <= calc_tgt;
            end
        end
    end

    assign bus.target   = target_q;
    assign bus.hit      = hit_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = sweeping;
endmodule
